stim_seq: RTL and testbench

Synthesizable on-chip stimulus sequencer for built-in self-test of a TinyTapeout user design. It drives a `CHANNELS`×`WIDTH` input bus into the design under test and holds the DUT reset low for a programmable number of cycles. It then runs a selectable pattern for a programmed cycle count and reports completion. With signature compression enabled it also folds the DUT response into a MISR. It sits between the tile I/O wrapper and the user core, replacing the fixed zero-stimulus, fixed-reset-hold bench flow.

---
 rtl/stim_seq_pkg.sv | 40 ++++
 rtl/stim_seq_chan.sv | 66 ++++++
 rtl/stim_seq.sv | 176 +++++++++++++++++
 tb/tb_stim_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stim_seq stimulus sequencer.
package stim_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    localparam int RESET_CYCLES_DEF = 25;

    // Feedback tap masks for a left-shifting Fibonacci LFSR whose new bit 0
    // is the XOR of the masked bits; every entry gives a maximal-length sequence.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/stim_seq_chan.sv
// One stimulus channel: seeds on load, steps its pattern on advance.
module stim_seq_chan
    import stim_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode,
    input  logic             load,
    input  logic             advance,
    input  logic [15:0]      chan_idx,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] nxt;

    // Seed and next-step value for the selected pattern.
    always_comb begin
        seed = '0;
        nxt  = val_q;
        case (mode)
            MODE_ZERO: begin
                seed = '0;
                nxt  = '0;
            end
            MODE_COUNT: begin
                seed = WIDTH'(chan_idx);
                nxt  = val_q + WIDTH'(1);
            end
            MODE_LFSR: begin
                seed = WIDTH'(chan_idx + 16'd1);
                if (seed == '0) begin
                    seed = WIDTH'(1);
                end
                nxt = {val_q[WIDTH-2:0], ^(val_q & TAPS)};
            end
            MODE_WALK: begin
                seed = WIDTH'(1) << (chan_idx % 16'(WIDTH));
                nxt  = {val_q[WIDTH-2:0], val_q[WIDTH-1]};
            end
            default: begin
                seed = '0;
                nxt  = val_q;
            end
        endcase
    end

    // Pattern register: load wins over advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else if (load) begin
            val_q <= seed;
        end else if (advance) begin
            val_q <= nxt;
        end
    end

    assign value = val_q;

endmodule

// File: rtl/stim_seq.sv
// Stimulus sequencer top: reset-hold, patterned run, completion pulse.
// Optional MISR signature of the DUT response: define STIM_SEQ_SIGNATURE_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold last values
// ST_RESET | dut_rst_n low, stim at seeds, reset down-counter running
// ST_RUN   | dut_rst_n high, pattern and cycle_cnt step every cycle
// ST_DONE  | one-cycle completion; start here restarts immediately
module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 2,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [CNT_W-1:0]          run_len,
`ifdef STIM_SEQ_SIGNATURE_EN
    input  logic [CHANNELS*WIDTH-1:0] resp,
    output logic [WIDTH-1:0]          signature,
`endif
    output logic                      dut_rst_n,
    output logic [CHANNELS*WIDTH-1:0] stim,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          cycle_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RESET_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    mode_e            mode_q;
    mode_e            chan_mode;
    logic [CNT_W-1:0] run_len_q;
    logic [CNT_W-1:0] rst_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             dut_rst_n_q;
    logic             busy_q;
    logic             done_q;
    logic             take;
    logic             chan_adv;

    // Next-state decode; the pattern advances on every edge that lands in RUN.
    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        chan_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RESET;
                    take    = 1'b1;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == '0) begin
                    if (run_len_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                        chan_adv = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q == run_len_q) begin
                    state_d = ST_DONE;
                end else begin
                    chan_adv = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RESET;
                    take    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Seeds must follow the mode being latched, not the previous run's.
    always_comb begin
        chan_mode = take ? mode_e'(mode) : mode_q;
    end

    // State, timers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ZERO;
            run_len_q   <= '0;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            dut_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RESET) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            if (take) begin
                mode_q      <= mode_e'(mode);
                run_len_q   <= run_len;
                rst_cnt_q   <= RST_LOAD;
                cycle_cnt_q <= '0;
                dut_rst_n_q <= 1'b0;
            end else begin
                if ((state_q == ST_RESET) && (rst_cnt_q != '0)) begin
                    rst_cnt_q <= rst_cnt_q - CNT_ONE;
                end
                if (chan_adv && (cycle_cnt_q != '1)) begin
                    cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
                end
                if ((state_d == ST_RUN) || (state_d == ST_DONE)) begin
                    dut_rst_n_q <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        stim_seq_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .mode    (chan_mode),
            .load    (take),
            .advance (chan_adv),
            .chan_idx(16'(k)),
            .value   (stim[k*WIDTH +: WIDTH])
        );
    end

`ifdef STIM_SEQ_SIGNATURE_EN
    localparam logic [WIDTH-1:0] MISR_TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] resp_fold;

    // XOR-fold all response channels into one WIDTH-bit word.
    always_comb begin
        resp_fold = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            resp_fold = resp_fold ^ resp[k*WIDTH +: WIDTH];
        end
    end

    // MISR compresses the response once per RUN cycle and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst || take) begin
            misr_q <= '0;
        end else if (state_q == ST_RUN) begin
            misr_q <= {misr_q[WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ resp_fold;
        end
    end

    assign signature = misr_q;
`endif

    assign dut_rst_n = dut_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_stim_seq.sv
// Scoreboard bench for stim_seq (WIDTH=8, CHANNELS=2, RESET_CYCLES=25).
module tb_stim_seq;

    localparam int RC = 25;

    typedef struct {
        int          rst_low;
        int          dur;
        logic [31:0] cnt;
        logic [15:0] stim;
        logic [7:0]  sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] run_len;
    logic        dut_rst_n;
    logic [15:0] stim;
    logic        busy;
    logic        done;
    logic [31:0] cycle_cnt;
`ifdef STIM_SEQ_SIGNATURE_EN
    logic [7:0]  signature;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] run_q[$];
    exp_t        done_q[$];

    stim_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .run_len  (run_len),
`ifdef STIM_SEQ_SIGNATURE_EN
        .resp     (stim),
        .signature(signature),
`endif
        .dut_rst_n(dut_rst_n),
        .stim     (stim),
        .busy     (busy),
        .done     (done),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] v);
        case (md)
            2'd0:    return 8'h00;
            2'd1:    return v + 8'd1;
            2'd2:    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            default: return {v[6:0], v[7]};
        endcase
    endfunction

    // Push the expected RUN-cycle stimulus and the completion record.
    task automatic push_exp(input logic [1:0] md, input int len);
        logic [7:0] v0;
        logic [7:0] v1;
        logic [7:0] m;
        exp_t       e;
        case (md)
            2'd0:    begin v0 = 8'd0; v1 = 8'd0; end
            2'd1:    begin v0 = 8'd0; v1 = 8'd1; end
            default: begin v0 = 8'd1; v1 = 8'd2; end
        endcase
        m = 8'd0;
        for (int i = 0; i < len; i++) begin
            v0 = model_next(md, v0);
            v1 = model_next(md, v1);
            run_q.push_back({v1, v0});
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ v0 ^ v1;
        end
        e.rst_low = RC;
        e.dur     = RC + len;
        e.cnt     = 32'(len);
        e.stim    = {v1, v0};
        e.sig     = m;
        done_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [1:0] md, input int len);
        start   = 1'b1;
        mode    = md;
        run_len = 32'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit seen_done;
        seen_done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        if (!seen_done) fail({name, "_timeout"});
        #1;
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_dut_rst_n"}, 64'(dut_rst_n), 64'd0);
        check({name, "_stim"}, 64'(stim), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
`ifdef STIM_SEQ_SIGNATURE_EN
        check({name, "_signature"}, 64'(signature), 64'd0);
`endif
    endtask

    // Monitor: pops expected stimulus on RUN cycles and the record on done.
    int          cyc = 0;
    int          t_busy = 0;
    int          rst_low = 0;
    logic        busy_d = 1'b0;
    logic [255:0] seen;
    int          seen_n = 0;
    always @(negedge clk) begin
        logic [15:0] es;
        exp_t        ed;
        cyc++;
        if (rst) begin
            busy_d = 1'b0;
        end else begin
            if (busy && !busy_d) begin
                t_busy  = cyc;
                rst_low = 0;
                seen    = '0;
                seen_n  = 0;
            end
            busy_d = busy;
            if (busy && !dut_rst_n) rst_low++;
            if (busy && dut_rst_n) begin
                if (run_q.size() == 0) begin
                    fail("run_stim_unexpected");
                end else begin
                    es = run_q.pop_front();
                    check("run_stim", 64'(stim), 64'(es));
                end
                if (!seen[stim[7:0]]) begin
                    seen[stim[7:0]] = 1'b1;
                    seen_n++;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    ed = done_q.pop_front();
                    check("rst_hold_len", 64'(rst_low), 64'(ed.rst_low));
                    check("busy_to_done", 64'(cyc - t_busy), 64'(ed.dur));
                    check("done_cycle_cnt", 64'(cycle_cnt), 64'(ed.cnt));
                    check("done_stim", 64'(stim), 64'(ed.stim));
                    check("done_rst_n", 64'(dut_rst_n), 64'd1);
`ifdef STIM_SEQ_SIGNATURE_EN
                    check("done_signature", 64'(signature), 64'(ed.sig));
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog at %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'd0;
        run_len = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Counter, short run.
        push_exp(2'd1, 10);
        pulse_start(2'd1, 10);
        wait_done(RC + 40, "cnt10");
        check_idle_after("cnt10");

        // Counter long run: both channels wrap, ch1 one ahead.
        push_exp(2'd1, 300);
        pulse_start(2'd1, 300);
        wait_done(RC + 330, "cnt300");
        check_idle_after("cnt300");

        // LFSR full period.
        push_exp(2'd2, 255);
        pulse_start(2'd2, 255);
        wait_done(RC + 290, "lfsr255");
        check("lfsr_distinct", 64'(seen_n), 64'd255);
        check("lfsr_back_to_seed", 64'(stim[7:0]), 64'd1);
        check_idle_after("lfsr255");

        // Walking-one past a full rotation, then zero pattern.
        push_exp(2'd3, 12);
        pulse_start(2'd3, 12);
        wait_done(RC + 40, "walk12");
        check_idle_after("walk12");
        push_exp(2'd0, 4);
        pulse_start(2'd0, 4);
        wait_done(RC + 40, "zero4");
        check_idle_after("zero4");

        // Zero-length run goes straight from RESET to DONE.
        push_exp(2'd1, 0);
        pulse_start(2'd1, 0);
        wait_done(RC + 20, "len0");
        check_idle_after("len0");

        // Start during RUN must be ignored.
        push_exp(2'd1, 20);
        pulse_start(2'd1, 20);
        repeat (RC + 5) @(posedge clk);
        #1;
        pulse_start(2'd2, 3);
        wait_done(RC + 40, "ign");
        check_idle_after("ign");

        // Start in DONE restarts without an IDLE cycle; same run twice.
        push_exp(2'd1, 16);
        pulse_start(2'd1, 16);
        wait_done(RC + 40, "rerun_a");
        push_exp(2'd1, 16);
        pulse_start(2'd1, 16);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_dut_rst_n", 64'(dut_rst_n), 64'd0);
        wait_done(RC + 40, "rerun_b");
        check_idle_after("rerun_b");

        // Reset in the middle of RUN.
        push_exp(2'd2, 50);
        pulse_start(2'd2, 50);
        repeat (RC + 6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_q.delete();
        done_q.delete();
        check_reset_vals("midrun");

        // Recovery after reset.
        push_exp(2'd1, 3);
        pulse_start(2'd1, 3);
        wait_done(RC + 30, "recover");
        check_idle_after("recover");

        check("queue_drained", 64'(run_q.size() + done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
